// File: rtl/rom_adder_pkg.sv
// Shared definitions for the ROM-fed streaming adder array.
//   state_t      : controller states (IDLE, FETCH, WAIT, OUT, DONE)
//   MODE_WRAP    : lane result wraps modulo 2^BW
//   MODE_SAT     : lane result clamps to all-ones on carry-out
//   lane_lsb()   : LSB position of a BW-wide slice inside a packed word
package rom_adder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Slice k of width bw starts at bit k*bw. Operand a of lane i is slice
    // 2*i, operand b is slice 2*i+1; result of lane i is slice i.
    function automatic int lane_lsb(input int slice, input int bw);
        return slice * bw;
    endfunction

endpackage

// File: rtl/rom_stream_adder_array_lane_adder.sv
// lane_adder: one combinational unsigned adder lane.
//   a, b   : BW-bit unsigned operands
//   sat    : MODE_WRAP / MODE_SAT
//   result : BW-bit wrapped or saturated sum
//   carry  : bit BW of the raw a+b sum (independent of sat)
module lane_adder
    import rom_adder_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic          sat,
    output logic [BW-1:0] result,
    output logic          carry
);

    logic [BW:0] raw;

    assign raw    = {1'b0, a} + {1'b0, b};
    assign carry  = raw[BW];
    assign result = (sat == MODE_SAT && carry) ? '1 : raw[BW-1:0];

endmodule

// File: rtl/rom_stream_adder_array.sv
// rom_stream_adder_array: walks DEPTH words of a synchronous ROM, adds the N
// packed operand pairs of each word in parallel and streams one result vector
// per word over a valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   start, sat_mode      : run request and wrap/saturate mode (latched at start)
//   rom_en, rom_addr     : ROM read port; rom_rdata valid the cycle after rom_en
//   sum_data, sum_carry  : lane results / raw carry-outs, held while stalled
//   sum_valid, sum_ready : result handshake
//   busy, done           : run in progress / one-cycle end-of-run pulse
// Optional build macro OVF_COUNT_EN adds ovf_count: per-lane 16-bit saturating
// count of accepted vectors with carry set during the current run.
module rom_stream_adder_array
    import rom_adder_pkg::*;
#(
    parameter int BW    = 8,
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sat_mode,
    output logic              rom_en,
    output logic [AW-1:0]     rom_addr,
    input  logic [2*N*BW-1:0] rom_rdata,
    output logic [N*BW-1:0]   sum_data,
    output logic [N-1:0]      sum_carry,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              done
`ifdef OVF_COUNT_EN
    ,
    output logic [N*16-1:0]   ovf_count
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t              state;
    logic                mode_q;
    logic [N-1:0][BW-1:0] lane_res;
    logic [N-1:0]        lane_carry;

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_adder #(.BW(BW)) u_lane (
            .a      (rom_rdata[lane_lsb(2*i,   BW) +: BW]),
            .b      (rom_rdata[lane_lsb(2*i+1, BW) +: BW]),
            .sat    (mode_q),
            .result (lane_res[i]),
            .carry  (lane_carry[i])
        );
    end

    // rom_addr doubles as the word counter: it only advances on accept, so
    // the address seen during FETCH is always the word being processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_WRAP;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            sum_data  <= '0;
            sum_carry <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rom_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= sat_mode;
                        rom_addr <= '0;
                        rom_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    sum_data  <= lane_res;
                    sum_carry <= lane_carry;
                    sum_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        if (rom_addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + AW'(1);
                            rom_en   <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OVF_COUNT_EN
    logic [N-1:0][15:0] ovf_q;

    assign ovf_count = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (state == IDLE && start) begin
            ovf_q <= '0;
        end else if (state == OUT && sum_ready) begin
            for (int i = 0; i < N; i++) begin
                if (sum_carry[i] && ovf_q[i] != 16'hFFFF)
                    ovf_q[i] <= ovf_q[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_stream_adder_array.sv
// Bench for rom_stream_adder_array (BW=8, N=4, DEPTH=4): table of hand-computed
// vectors, randomized runs against an arithmetic reference model, backpressure,
// mid-run noise on start/sat_mode, and a mid-run asynchronous reset.
module tb_rom_stream_adder_array;

    localparam int BW    = 8;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sat_mode = 1'b0;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [2*N*BW-1:0] rom_rdata = '0;
    logic [N*BW-1:0]   sum_data;
    logic [N-1:0]      sum_carry;
    logic              sum_valid;
    logic              sum_ready = 1'b1;
    logic              busy;
    logic              done;
`ifdef OVF_COUNT_EN
    logic [N*16-1:0]   ovf_count;
`endif

    logic [2*N*BW-1:0] rom_mem [DEPTH];

    int n_pass = 0;
    int n_total = 0;

    rom_stream_adder_array #(.BW(BW), .N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sat_mode  (sat_mode),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .sum_data  (sum_data),
        .sum_carry (sum_carry),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .done      (done)
`ifdef OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after rom_en.
    always @(posedge clk) begin
        if (rom_en) rom_rdata <= rom_mem[rom_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [2*N*BW-1:0] pack(input int a0, input int b0, input int a1, input int b1,
                                               input int a2, input int b2, input int a3, input int b3);
        return {BW'(b3), BW'(a3), BW'(b2), BW'(a2), BW'(b1), BW'(a1), BW'(b0), BW'(a0)};
    endfunction

    // Reference: plain integer addition per lane, then wrap or clamp.
    function automatic void model(input logic [2*N*BW-1:0] w, input bit m,
                                  output logic [N*BW-1:0] d, output logic [N-1:0] c);
        d = '0;
        c = '0;
        for (int i = 0; i < N; i++) begin
            int a, b, s;
            a = int'(w[2*i*BW +: BW]);
            b = int'(w[(2*i+1)*BW +: BW]);
            s = a + b;
            c[i] = (s >= (1 << BW));
            d[i*BW +: BW] = (m && c[i]) ? BW'((1 << BW) - 1) : BW'(s % (1 << BW));
        end
    endfunction

    // Called at a negedge. Starts a run and follows it to done, checking every
    // accepted vector, the address sequence, stall stability and busy.
    task automatic do_run(input bit mode, input int rdy_pct, input int stall_first, input bit noise,
                          output logic [N*BW-1:0] first_data, output logic [N-1:0] first_carry,
                          output int en_cyc, output int val_cyc, output int done_cyc);
        int cyc, nacc, naddr, stall_left;
        bit stalled;
        logic [N*BW-1:0] held_d, ed;
        logic [N-1:0] held_c, ec;
        en_cyc = -1; val_cyc = -1; done_cyc = -1;
        first_data = '0; first_carry = '0;
        nacc = 0; naddr = 0; stall_left = 0; stalled = 0;
        held_d = '0; held_c = '0;
        sat_mode = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc <= 40 * DEPTH + 20) begin
            if (noise) begin
                start = 1'($urandom);
                sat_mode = 1'($urandom);
            end
            chk("busy_in_run", busy, 1);
            if (stalled) begin
                chk("hold_valid", sum_valid, 1);
                chk("hold_data", sum_data, held_d);
                chk("hold_carry", sum_carry, held_c);
            end
            if (rom_en) begin
                if (en_cyc < 0) en_cyc = cyc;
                chk("rom_addr_seq", rom_addr, naddr);
                naddr++;
            end
            if (sum_valid) begin
                chk("no_fetch_while_valid", rom_en, 0);
                if (val_cyc < 0) begin
                    val_cyc = cyc;
                    stall_left = stall_first;
                end
                sum_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
                if (stall_left > 0) stall_left--;
                if (sum_ready) begin
                    if (nacc < DEPTH) begin
                        model(rom_mem[nacc], mode, ed, ec);
                        chk("sum_data", sum_data, ed);
                        chk("sum_carry", sum_carry, ec);
                    end else begin
                        chk("extra_vector", nacc, DEPTH - 1);
                    end
                    if (nacc == 0) begin
                        first_data = sum_data;
                        first_carry = sum_carry;
                    end
                    nacc++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d = sum_data;
                    held_c = sum_carry;
                end
            end else begin
                sum_ready = ($urandom_range(99) < rdy_pct);
            end
            if (done) begin
                done_cyc = cyc;
                chk("accepted_count", nacc, DEPTH);
                chk("fetch_count", naddr, DEPTH);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        sum_ready = 1'b1;
        if (done_cyc < 0) begin
            n_total++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", 40 * DEPTH + 20);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    typedef struct {
        logic [2*N*BW-1:0] word;
        bit                mode;
        logic [N*BW-1:0]   exp_data;
        logic [N-1:0]      exp_carry;
    } vec_t;

    initial begin
        vec_t tbl [6];
        logic [N*BW-1:0] fd;
        logic [N-1:0] fc;
        int ec, vc, dc, k;
        bit seen_done;

        tbl[0] = '{pack(1, 2, 100, 27, 255, 1, 128, 128), 1'b0, 32'h0000_7F03, 4'b1100};
        tbl[1] = '{pack(1, 2, 100, 27, 255, 1, 128, 128), 1'b1, 32'hFFFF_7F03, 4'b1100};
        tbl[2] = '{pack(0, 0, 255, 0, 200, 55, 200, 56), 1'b0, 32'h00FF_FF00, 4'b1000};
        tbl[3] = '{pack(0, 0, 255, 0, 200, 55, 200, 56), 1'b1, 32'hFFFF_FF00, 4'b1000};
        tbl[4] = '{pack(255, 255, 1, 254, 127, 128, 16, 17), 1'b1, 32'h21FF_FFFF, 4'b0001};
        tbl[5] = '{pack(255, 255, 1, 254, 127, 128, 16, 17), 1'b0, 32'h21FF_FFFE, 4'b0001};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_sum_data", sum_data, 0);
        chk("rst_sum_carry", sum_carry, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", busy, 0);

        // Table: each word replicated across the ROM, ready held high.
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < DEPTH; w++) rom_mem[w] = tbl[t].word;
            do_run(tbl[t].mode, 100, 0, 1'b0, fd, fc, ec, vc, dc);
            chk($sformatf("tbl%0d_data", t), fd, tbl[t].exp_data);
            chk($sformatf("tbl%0d_carry", t), fc, tbl[t].exp_carry);
            chk($sformatf("tbl%0d_rom_en_cycle", t), ec, 1);
            chk($sformatf("tbl%0d_first_valid_cycle", t), vc, 3);
            chk($sformatf("tbl%0d_done_cycle", t), dc, 3 * DEPTH + 1);
`ifdef OVF_COUNT_EN
            chk($sformatf("tbl%0d_ovf_count", t), ovf_count,
                {16'(DEPTH * tbl[t].exp_carry[3]), 16'(DEPTH * tbl[t].exp_carry[2]),
                 16'(DEPTH * tbl[t].exp_carry[1]), 16'(DEPTH * tbl[t].exp_carry[0])});
`endif
        end

        // Backpressure: ready low for 5 cycles after the first valid.
        for (int w = 0; w < DEPTH; w++) rom_mem[w] = {$urandom, $urandom};
        do_run(1'b0, 100, 5, 1'b0, fd, fc, ec, vc, dc);
        chk("bp_done_cycle", dc, 3 * DEPTH + 1 + 5);

        // Randomized runs, some with start/sat_mode toggling mid-run.
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < DEPTH; w++) rom_mem[w] = {$urandom, $urandom};
            do_run(1'($urandom), $urandom_range(100, 30), 0, r[0], fd, fc, ec, vc, dc);
        end

        // Asynchronous reset during OUT of word 2.
        for (int w = 0; w < DEPTH; w++) rom_mem[w] = {$urandom, $urandom};
        sat_mode = 1'b0;
        sum_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        seen_done = 0;
        while (!(sum_valid && rom_addr == 2) && k < 100) begin
            sum_ready = sum_valid;
            if (done) seen_done = 1;
            @(negedge clk);
            k++;
        end
        chk("reached_word2_out", sum_valid && rom_addr == 2, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rom_en", rom_en, 0);
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_sum_data", sum_data, 0);
        chk("abort_sum_carry", sum_carry, 0);
        chk("abort_sum_valid", sum_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("no_partial_done", seen_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sum_ready = 1'b1;
        @(negedge clk);
        do_run(1'b1, 100, 0, 1'b0, fd, fc, ec, vc, dc);
        chk("rerun_done_cycle", dc, 3 * DEPTH + 1);
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("single_done", seen_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_stream_adder_array.md
Name: rom_stream_adder_array

Overview:
Parametrised successor to the single-shot ROM-fed adder top. It walks a synchronous ROM of DEPTH words, each packing N operand pairs, and adds all N lanes in parallel. It streams one BW-bit-per-lane result vector per word over a valid/ready handshake, with a run-time wrap/saturate mode. It sits between the operand ROM and a result sink (checker or dump logic) in the top-level test design.

Parameters:
BW, 8, lane operand/result width in bits (>=2)
N, 4, number of parallel adder lanes (>=1)
DEPTH, 16, number of ROM words processed per run (>=1)
AW, $clog2(DEPTH) (min 1), ROM address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
sat_mode  in  1  0 = wrap modulo 2^BW, 1 = unsigned saturate; latched at start
rom_en  out  1  ROM read enable
rom_addr  out  AW  ROM word address
rom_rdata  in  2*N*BW  ROM word, valid the cycle after rom_en
sum_data  out  N*BW  lane i result at [i*BW +: BW]
sum_carry  out  N  lane i carry-out of the raw BW+1-bit sum
sum_valid  out  1  result vector valid
sum_ready  in  1  sink accepts the vector when valid&&ready
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last vector is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; rom_en=0, rom_addr=0, sum_data=0, sum_carry=0, sum_valid=0, busy=0, done=0, latched mode=0.
- Operand layout: lane i a = rom_rdata[2*i*BW +: BW], b = rom_rdata[(2*i+1)*BW +: BW]. Unsigned.
- FSM states: IDLE, FETCH, WAIT, OUT, DONE.
- IDLE: start=1 latches sat_mode, clears the word counter, and moves to FETCH. start=0 stays in IDLE.
- FETCH: drives rom_en=1 and rom_addr=counter for exactly one cycle, then moves to WAIT.
- WAIT: rom_rdata is valid. Each lane computes raw = a+b (BW+1 bits). carry = raw[BW]. Result = raw[BW-1:0] if mode=0; if mode=1, result = all-ones when carry=1, else raw[BW-1:0]. The registered result appears with sum_valid=1 next cycle; move to OUT.
- OUT: sum_data and sum_carry are held stable while sum_valid=1 and sum_ready=0.
  - On accept with counter==DEPTH-1, go to DONE.
  - Otherwise increment the counter and go to FETCH.
  - sum_valid drops the cycle after accept.
- DONE: done=1 for one cycle, then IDLE. sum_data retains its last value.
- Latency: with start at cycle 0 and ready held high, rom_en is at cycle 1 and the first sum_valid at cycle 3. One vector is produced per 3 cycles. A full run is 3*DEPTH+1 cycles from start to done.
- start while busy is ignored; sat_mode changes mid-run are ignored.
- sum_ready high while sum_valid is low has no effect.
- Counter never wraps; addresses 0..DEPTH-1 are each read exactly once, in order.
- DEPTH=1: a single word is read, then DONE.
- Async reset mid-run aborts immediately to reset values. No partial done is issued.

Optional Feature:
OVF_COUNT_EN
- Defined: adds output ovf_count (N*16 bits). Lane i holds a 16-bit saturating count of accepted vectors with sum_carry[i]=1 in the current run. It is cleared on start-accept and on reset, and is stable after done.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package rom_adder_pkg: state enum (IDLE, FETCH, WAIT, OUT, DONE), MODE_WRAP=1'b0 / MODE_SAT=1'b1 constants, and a lane slice helper function.
- Sub-module lane_adder (params BW): combinational a, b, sat → result, carry; instantiated N times via generate. FSM, registers and handshake live in the top module.

Test Plan:
- BW=8, N=4, DEPTH=4, mode 0, ready=1; word0 lanes (1+2, 100+27, 255+1, 128+128) → sum_data lanes 3, 127, 0, 0; carry=4'b1100; first valid at cycle 3; done at cycle 13.
- Same word0, mode 1 → lanes 3, 127, 255, 255; carry=4'b1100.
- Backpressure: ready=0 for 5 cycles after the first valid → sum_data stable and valid held; no rom_en asserted until accept; rom_addr sequence is 0,1,2,3 with no skips.
- start pulsed during busy, and sat_mode toggled mid-run → no restart; all vectors use the mode latched at start.
- rst_n low during OUT of word 2 → all outputs 0 immediately; a new start re-reads from address 0; done occurs only once, at the end of the new run.
- OVF_COUNT_EN defined, word0 repeated in all 4 words → ovf_count lanes 0,0,4,4 at done; cleared to 0 on the next start.
